// File: rtl/led_pkg.sv
// Shared definitions for the RGB status-LED driver: palette, mode encoding,
// LED bit order and the small state enums used by the modulation generator.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_STEADY  = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int unsigned LED_R = 2;
  localparam int unsigned LED_G = 1;
  localparam int unsigned LED_B = 0;

  // Entry N is the {R,G,B} triple for colour code N.
  localparam logic [7:0][2:0] PALETTE = {
    3'b111, 3'b001, 3'b010, 3'b100,
    3'b011, 3'b101, 3'b110, 3'b000
  };

  function automatic logic [2:0] palette_rgb(input logic [2:0] code);
    return PALETTE[code];
  endfunction

endpackage

// File: rtl/led_mod_gen.sv
// Per-period modulation generator: turns the active mode/brightness into a
// duty value, owning the blink phase and the breathe level/direction.
module led_mod_gen
  import led_pkg::*;
#(
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned BLINK_HALF = 16384,
  parameter int unsigned STEP_DIV   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             wrap,
  input  logic             mode_chg,
  input  mode_e            nx_mode,
  input  logic [PWM_W-1:0] nx_bright,
  input  mode_e            act_mode,
  input  logic [PWM_W-1:0] act_bright,
  output logic [PWM_W-1:0] duty
);

  localparam int unsigned BC_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned SC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(BLINK_HALF - 1);
  localparam logic [SC_W-1:0] STEP_LAST  = SC_W'(STEP_DIV - 1);

  logic [BC_W-1:0]  blink_cnt, blink_cnt_n;
  logic [SC_W-1:0]  step_cnt, step_cnt_n;
  logic [PWM_W-1:0] level, level_n;
  logic [PWM_W-1:0] lvl_base;
  logic             going_up;
  phase_e           phase, phase_n;
  dir_e             dir, dir_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      step_cnt  <= '0;
      level     <= '0;
      phase     <= PH_ON;
      dir       <= DIR_UP;
    end else begin
      blink_cnt <= blink_cnt_n;
      step_cnt  <= step_cnt_n;
      level     <= level_n;
      phase     <= phase_n;
      dir       <= dir_n;
    end
  end

  // Counters advance only in the mode that is being committed at this wrap;
  // a mode change restarts them and that wrap does not count as a step.
  always_comb begin
    blink_cnt_n = blink_cnt;
    step_cnt_n  = step_cnt;
    level_n     = level;
    phase_n     = phase;
    dir_n       = dir;
    lvl_base    = (level > nx_bright) ? nx_bright : level;
    going_up    = ((dir == DIR_UP) && (lvl_base < nx_bright)) ||
                  ((dir == DIR_DOWN) && (lvl_base == '0));
    if (!enable) begin
      blink_cnt_n = '0;
      step_cnt_n  = '0;
      level_n     = '0;
      phase_n     = PH_ON;
      dir_n       = DIR_UP;
    end else if (wrap) begin
      level_n = lvl_base;
      if (mode_chg) begin
        blink_cnt_n = '0;
        step_cnt_n  = '0;
        phase_n     = PH_ON;
        dir_n       = DIR_UP;
      end else begin
        if (nx_mode == MODE_BLINK) begin
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt_n = '0;
            phase_n     = (phase == PH_ON) ? PH_OFF : PH_ON;
          end else begin
            blink_cnt_n = blink_cnt + 1'b1;
          end
        end
        if (nx_mode == MODE_BREATHE) begin
          if (step_cnt == STEP_LAST) begin
            step_cnt_n = '0;
            if (nx_bright == '0) begin
              level_n = '0;
              dir_n   = DIR_UP;
            end else if (going_up) begin
              level_n = lvl_base + 1'b1;
              dir_n   = (level_n == nx_bright) ? DIR_DOWN : DIR_UP;
            end else begin
              level_n = lvl_base - 1'b1;
              dir_n   = (level_n == '0) ? DIR_UP : DIR_DOWN;
            end
          end else begin
            step_cnt_n = step_cnt + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    duty = act_bright;
    case (act_mode)
      MODE_BLINK:   duty = (phase == PH_ON) ? act_bright : '0;
      MODE_BREATHE: duty = level;
      default:      duty = act_bright;
    endcase
  end

endmodule

// File: rtl/rgb_led_pwm.sv
// RGB status-LED driver: shadow/active settings committed on PWM wrap,
// free-running PWM counter, duty compare and registered LED drives.
module rgb_led_pwm
  import led_pkg::*;
#(
  parameter int unsigned CODE_W     = 2,
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned BLINK_HALF = 16384,
  parameter int unsigned STEP_DIV   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              main_program,
  input  logic              load,
  input  logic [CODE_W-1:0] input_value,
  input  logic [1:0]        mode,
  input  logic [PWM_W-1:0]  brightness,
  output logic              red_led,
  output logic              green_led,
  output logic              blue_led,
  output logic              period_start
);

  logic [PWM_W-1:0]  pwm_cnt;
  logic              wrap;
  logic [CODE_W-1:0] sh_code, act_code, nx_code;
  mode_e             sh_mode, act_mode, nx_mode;
  logic [PWM_W-1:0]  sh_bright, act_bright, nx_bright;
  logic              mode_chg;
  logic [PWM_W-1:0]  duty;
  logic              pwm_on;
  logic [2:0]        rgb;

  assign wrap = &pwm_cnt;

  // A load landing on the wrap cycle bypasses the shadow and commits at once.
  assign nx_code   = load ? input_value    : sh_code;
  assign nx_mode   = load ? mode_e'(mode)  : sh_mode;
  assign nx_bright = load ? brightness     : sh_bright;
  assign mode_chg  = wrap && (nx_mode != act_mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt    <= '0;
      sh_code    <= '0;
      sh_mode    <= MODE_STEADY;
      sh_bright  <= '0;
      act_code   <= '0;
      act_mode   <= MODE_STEADY;
      act_bright <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (load) begin
        sh_code   <= input_value;
        sh_mode   <= mode_e'(mode);
        sh_bright <= brightness;
      end
      if (wrap) begin
        act_code   <= nx_code;
        act_mode   <= nx_mode;
        act_bright <= nx_bright;
      end
    end
  end

  led_mod_gen #(
    .PWM_W      (PWM_W),
    .BLINK_HALF (BLINK_HALF),
    .STEP_DIV   (STEP_DIV)
  ) u_mod_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (main_program),
    .wrap       (wrap),
    .mode_chg   (mode_chg),
    .nx_mode    (nx_mode),
    .nx_bright  (nx_bright),
    .act_mode   (act_mode),
    .act_bright (act_bright),
    .duty       (duty)
  );

  assign pwm_on = (&duty) | (pwm_cnt < duty);
  assign rgb    = palette_rgb(3'(act_code));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_led      <= 1'b0;
      green_led    <= 1'b0;
      blue_led     <= 1'b0;
      period_start <= 1'b0;
    end else begin
      red_led      <= pwm_on & rgb[LED_R] & main_program;
      green_led    <= pwm_on & rgb[LED_G] & main_program;
      blue_led     <= pwm_on & rgb[LED_B] & main_program;
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Directed and randomized bench for rgb_led_pwm against an integer-level
// behavioural model of the palette, commit and modulation rules.
module tb_rgb_led_pwm;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned PWM_W  = 4;
  localparam int unsigned BH     = 2;
  localparam int unsigned SD     = 1;
  localparam int          P      = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              main_program = 1'b0;
  logic              load = 1'b0;
  logic [CODE_W-1:0] input_value = '0;
  logic [1:0]        mode = '0;
  logic [PWM_W-1:0]  brightness = '0;
  logic              red_led, green_led, blue_led, period_start;

  int total = 0;
  int bad   = 0;

  rgb_led_pwm #(
    .CODE_W     (CODE_W),
    .PWM_W      (PWM_W),
    .BLINK_HALF (BH),
    .STEP_DIV   (SD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .main_program (main_program),
    .load         (load),
    .input_value  (input_value),
    .mode         (mode),
    .brightness   (brightness),
    .red_led      (red_led),
    .green_led    (green_led),
    .blue_led     (blue_led),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  // Colour bit per code, bit index = code.
  bit [7:0] pal_r = 8'b1001_0110;
  bit [7:0] pal_g = 8'b1010_1010;
  bit [7:0] pal_b = 8'b1100_1100;

  int m_cnt, m_sc, m_sm, m_sb, m_code, m_mode, m_br;
  int m_level, m_blink, m_step;
  bit m_phase_on, m_up;
  bit e_r, e_g, e_b, e_ps;

  task automatic model_reset();
    m_cnt = 0; m_sc = 0; m_sm = 0; m_sb = 0;
    m_code = 0; m_mode = 0; m_br = 0;
    m_level = 0; m_blink = 0; m_step = 0;
    m_phase_on = 1; m_up = 1;
    e_r = 0; e_g = 0; e_b = 0; e_ps = 0;
  endtask

  task automatic model_step();
    int duty, nc, nm, nb, eff;
    bit on, wrap, chg;
    wrap = (m_cnt == P - 1);
    eff  = (m_mode == 3) ? 0 : m_mode;
    if (eff == 1)      duty = m_phase_on ? m_br : 0;
    else if (eff == 2) duty = m_level;
    else               duty = m_br;
    on   = (duty == P - 1) || (m_cnt < duty);
    e_r  = main_program && on && pal_r[m_code];
    e_g  = main_program && on && pal_g[m_code];
    e_b  = main_program && on && pal_b[m_code];
    e_ps = wrap;
    nc = load ? int'(input_value) : m_sc;
    nm = load ? int'(mode)        : m_sm;
    nb = load ? int'(brightness)  : m_sb;
    if (load) begin m_sc = nc; m_sm = nm; m_sb = nb; end
    chg = wrap && (nm != m_mode);
    if (wrap) begin m_code = nc; m_mode = nm; m_br = nb; end
    if (!main_program) begin
      m_level = 0; m_blink = 0; m_step = 0; m_phase_on = 1; m_up = 1;
    end else if (wrap) begin
      if (m_level > nb) m_level = nb;
      if (chg) begin
        m_blink = 0; m_step = 0; m_phase_on = 1; m_up = 1;
      end else begin
        if (nm == 1) begin
          m_blink++;
          if (m_blink == BH) begin m_blink = 0; m_phase_on = !m_phase_on; end
        end
        if (nm == 2) begin
          m_step++;
          if (m_step == SD) begin
            m_step = 0;
            if (nb == 0) begin
              m_level = 0; m_up = 1;
            end else begin
              if (m_up && m_level >= nb) m_up = 0;
              if (!m_up && m_level == 0) m_up = 1;
              m_level = m_up ? m_level + 1 : m_level - 1;
              if (m_level == nb) m_up = 0;
              if (m_level == 0)  m_up = 1;
            end
          end
        end
      end
    end
    m_cnt = (m_cnt + 1) % P;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    chk("red",          red_led,      e_r);
    chk("green",        green_led,    e_g);
    chk("blue",         blue_led,     e_b);
    chk("period_start", period_start, e_ps);
  endtask

  task automatic do_load(input int code, input int md, input int br);
    input_value = CODE_W'(code);
    mode        = 2'(md);
    brightness  = PWM_W'(br);
    load        = 1'b1;
    tick();
    load        = 1'b0;
  endtask

  // Count LED-high cycles over the 16 outputs produced by one PWM period.
  task automatic measure(output int r, output int g, output int b);
    int n;
    r = 0; g = 0; b = 0; n = 0;
    while (period_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("period_start_timeout", 32'(n), 32'(0));
    for (int i = 0; i < P; i++) begin
      tick();
      r += int'(red_led); g += int'(green_led); b += int'(blue_led);
    end
  endtask

  task automatic expect_period(input string tag, input int er, input int eg, input int eb);
    int r, g, b;
    measure(r, g, b);
    chk({tag, "_r"}, 32'(r), 32'(er));
    chk({tag, "_g"}, 32'(g), 32'(eg));
    chk({tag, "_b"}, 32'(b), 32'(eb));
  endtask

  initial begin
    int n, r, g, b;
    int blink_exp[5];
    int breathe_exp[8];
    blink_exp   = '{8, 8, 0, 0, 8};
    breathe_exp = '{0, 1, 2, 3, 2, 1, 0, 1};

    model_reset();
    for (int i = 0; i < 3; i++) tick();
    chk("reset_red",   red_led,      1'b0);
    chk("reset_green", green_led,    1'b0);
    chk("reset_blue",  blue_led,     1'b0);
    chk("reset_ps",    period_start, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    main_program = 1'b1;

    do_load(1, 0, 4);
    expect_period("steady", 4, 4, 0);
    expect_period("steady2", 4, 4, 0);

    do_load(7, 0, 15);
    expect_period("full", 16, 16, 16);
    expect_period("full2", 16, 16, 16);
    do_load(7, 0, 0);
    expect_period("zero", 0, 0, 0);

    do_load(6, 1, 8);
    for (int i = 0; i < 5; i++) begin
      measure(r, g, b);
      chk("blink_b", 32'(b), 32'(blink_exp[i]));
      chk("blink_rg", 32'(r + g), 32'(0));
    end

    do_load(4, 2, 3);
    for (int i = 0; i < 8; i++) begin
      measure(r, g, b);
      chk("breathe_r", 32'(r), 32'(breathe_exp[i]));
    end

    do_load(1, 0, 4);
    expect_period("pre_collide", 4, 4, 0);
    for (int i = 0; i < P - 1; i++) tick();
    do_load(3, 0, 4);
    chk("collide_ps", period_start, 1'b1);
    expect_period("collide", 0, 4, 4);

    for (int i = 0; i < 5; i++) tick();
    do_load(4, 0, 6);
    n = 0;
    while (period_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("midload_align", 32'(n), 32'(10));
    expect_period("midload", 6, 0, 0);

    do_load(7, 0, 15);
    expect_period("pre_disable", 16, 16, 16);
    for (int i = 0; i < 3; i++) tick();
    main_program = 1'b0;
    tick();
    chk("disable_r", red_led,   1'b0);
    chk("disable_g", green_led, 1'b0);
    chk("disable_b", blue_led,  1'b0);
    for (int i = 0; i < 20; i++) tick();
    main_program = 1'b1;
    expect_period("reenable", 16, 16, 16);

    do_load(4, 2, 3);
    for (int i = 0; i < 4; i++) measure(r, g, b);
    for (int i = 0; i < 7; i++) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_r",  red_led,      1'b0);
    chk("async_rst_g",  green_led,    1'b0);
    chk("async_rst_b",  blue_led,     1'b0);
    chk("async_rst_ps", period_start, 1'b0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (period_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("rst_release_align", 32'(n), 32'(16));
    do_load(4, 2, 3);
    for (int i = 0; i < 4; i++) begin
      measure(r, g, b);
      chk("restart_breathe_r", 32'(r), 32'(breathe_exp[i]));
    end

    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(0, 14) == 0);
      input_value = CODE_W'($urandom_range(0, 7));
      mode = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       brightness = '0;
        1:       brightness = '1;
        default: brightness = PWM_W'($urandom_range(0, P - 1));
      endcase
      if ($urandom_range(0, 149) == 0) main_program = !main_program;
      tick();
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
